// File: rtl/led_scanner_if.sv
// Signal bundle between the LED scanner and its controller: run controls in, pattern and status out.
interface led_scanner_if #(
    parameter int N_LEDS = 8,
    parameter int DIV_W  = 16
);
    localparam int PW = $clog2(N_LEDS);

    logic              enable;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [N_LEDS-1:0] leds;
    logic [PW-1:0]     pos;
    logic              dir;
    logic              cycle_done;

    modport master (
        output enable, mode, div,
        input  leds, pos, dir, cycle_done
    );

    modport slave (
        input  enable, mode, div,
        output leds, pos, dir, cycle_done
    );
endinterface

// File: rtl/led_scanner.sv
// Parametrised LED scanner: prescaled stepping of a head position with bounce,
// rotate-left, rotate-right and bar-fill patterns.
module led_scanner #(
    parameter int N_LEDS = 8,
    parameter int DIV_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    led_scanner_if.slave  bus
);
    localparam int PW = $clog2(N_LEDS);
    localparam logic [PW-1:0]    POS_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    POS_ONE  = PW'(1);
    localparam logic [PW-1:0]    POS_LAST = PW'(N_LEDS - 1);
    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    mode_e             mode_s;
    logic              step_s;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              cycle_done_q, cycle_done_d;
    logic [N_LEDS-1:0] leds_s;

    assign mode_s = mode_e'(bus.mode);

    // Prescaler and position/direction next-state
    always_comb begin
        step_s       = 1'b0;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        cycle_done_d = 1'b0;
        if (bus.enable) begin
            // ">=" so that lowering div below the running count steps right away
            step_s = (cnt_q >= bus.div);
            if (step_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            step_s = 1'b0;
        end
        if (step_s) begin
            case (mode_s)
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (pos_q == POS_LAST) begin
                            pos_d = pos_q - POS_ONE;
                            dir_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == POS_ZERO) begin
                            pos_d = POS_ONE;
                            dir_d = 1'b0;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                end
                MODE_ROT_R: begin
                    pos_d = (pos_q == POS_ZERO) ? POS_LAST : pos_q - POS_ONE;
                    dir_d = 1'b1;
                end
                MODE_ROT_L, MODE_FILL: begin
                    pos_d = (pos_q == POS_LAST) ? POS_ZERO : pos_q + POS_ONE;
                    dir_d = 1'b0;
                end
                default: begin
                    pos_d = pos_q;
                    dir_d = dir_q;
                end
            endcase
            cycle_done_d = (pos_d == POS_ZERO);
        end else begin
            cycle_done_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= CNT_ZERO;
            pos_q        <= POS_ZERO;
            dir_q        <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Pattern decode follows the live mode so a mode switch shows without waiting for a step
    always_comb begin
        leds_s = {N_LEDS{1'b0}};
        for (int i = 0; i < N_LEDS; i++) begin
            if (mode_s == MODE_FILL) begin
                leds_s[i] = (PW'(i) <= pos_q);
            end else begin
                leds_s[i] = (PW'(i) == pos_q);
            end
        end
    end

    assign bus.leds       = leds_s;
    assign bus.pos        = pos_q;
    assign bus.dir        = dir_q;
    assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner (N_LEDS=8): expectations are queued as stimulus is applied
// and compared against the outputs one time unit after each rising edge.
module tb_led_scanner;
    typedef struct packed {
        logic [7:0] leds;
        logic [2:0] pos;
        logic       dir;
        logic       cd;
    } exp_t;

    logic  clk;
    logic  reset;
    int    checks;
    int    errors;
    string cur_test;
    exp_t  sb[$];

    led_scanner_if #(.N_LEDS(8), .DIV_W(16)) bus ();

    led_scanner #(.N_LEDS(8), .DIV_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(logic [7:0] l, logic [2:0] p, logic d, logic c);
        exp_t e;
        e.leds = l;
        e.pos  = p;
        e.dir  = d;
        e.cd   = c;
        sb.push_back(e);
    endfunction

    function automatic void push_oh(int p, logic d, logic c);
        logic [7:0] one;
        one = 8'h01;
        push(one << p, 3'(p), d, c);
    endfunction

    task automatic check_now();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got 0 entries required 1", cur_test);
        end else begin
            e = sb.pop_front();
            if (bus.leds !== e.leds) begin
                errors++;
                $display("FAIL %s leds got %h required %h t=%0t", cur_test, bus.leds, e.leds, $time);
            end
            checks++;
            if (bus.pos !== e.pos) begin
                errors++;
                $display("FAIL %s pos got %0d required %0d t=%0t", cur_test, bus.pos, e.pos, $time);
            end
            checks++;
            if (bus.dir !== e.dir) begin
                errors++;
                $display("FAIL %s dir got %b required %b t=%0t", cur_test, bus.dir, e.dir, $time);
            end
            checks++;
            if (bus.cycle_done !== e.cd) begin
                errors++;
                $display("FAIL %s cycle_done got %b required %b t=%0t", cur_test, bus.cycle_done, e.cd, $time);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.enable = 1'b0;
        #1;
        push(8'h01, 3'd0, 1'b0, 1'b0);
        check_now();
        for (int i = 0; i < 3; i++) begin
            push(8'h01, 3'd0, 1'b0, 1'b0);
            cycle();
        end
        #2;
        reset = 1'b0;
        push(8'h01, 3'd0, 1'b0, 1'b0);
        check_now();
    endtask

    task automatic test_reset();
        cur_test   = "reset";
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.div    = 16'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            push(8'h01, 3'd0, 1'b0, 1'b0);
            cycle();
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push(8'h01, 3'd0, 1'b0, 1'b0);
            cycle();
        end
    endtask

    task automatic test_bounce();
        int bp[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        bit bd[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        cur_test = "bounce";
        do_reset();
        bus.mode   = 2'b00;
        bus.div    = 16'd0;
        bus.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_oh(bp[i], bd[i], (i == 13));
            cycle();
        end
    endtask

    task automatic test_prescaler();
        cur_test = "prescaler";
        do_reset();
        bus.mode   = 2'b00;
        bus.div    = 16'd3;
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin push_oh(0, 1'b0, 1'b0); cycle(); end
        push_oh(1, 1'b0, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin push_oh(1, 1'b0, 1'b0); cycle(); end
        push_oh(2, 1'b0, 1'b0); cycle();
        push_oh(2, 1'b0, 1'b0); cycle();
        push_oh(2, 1'b0, 1'b0); cycle();
        cur_test   = "freeze";
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin push_oh(2, 1'b0, 1'b0); cycle(); end
        cur_test   = "resume";
        bus.enable = 1'b1;
        push_oh(2, 1'b0, 1'b0); cycle();
        push_oh(3, 1'b0, 1'b0); cycle();
        push_oh(3, 1'b0, 1'b0); cycle();
        push_oh(3, 1'b0, 1'b0); cycle();
        cur_test = "div_lower";
        bus.div  = 16'd0;
        push_oh(4, 1'b0, 1'b0); cycle();
        push_oh(5, 1'b0, 1'b0); cycle();
    endtask

    task automatic test_rotate();
        cur_test = "rot_l";
        do_reset();
        bus.mode   = 2'b01;
        bus.div    = 16'd0;
        bus.enable = 1'b1;
        for (int p = 1; p < 8; p++) begin push_oh(p, 1'b0, 1'b0); cycle(); end
        push_oh(0, 1'b0, 1'b1); cycle();
        push_oh(1, 1'b0, 1'b0); cycle();
        cur_test = "rot_r";
        bus.mode = 2'b10;
        push_oh(0, 1'b1, 1'b1); cycle();
        push_oh(7, 1'b1, 1'b0); cycle();
        push_oh(6, 1'b1, 1'b0); cycle();
    endtask

    task automatic test_fill();
        logic [7:0] fl[9] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01, 8'h03};
        cur_test = "fill";
        do_reset();
        bus.mode   = 2'b11;
        bus.div    = 16'd0;
        bus.enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(fl[i], (i < 7) ? 3'(i + 1) : ((i == 7) ? 3'd0 : 3'd1), 1'b0, (i == 7));
            cycle();
        end
    endtask

    task automatic test_mode_switch();
        int bp[9] = '{1, 2, 3, 4, 5, 6, 7, 6, 5};
        cur_test = "async_reset";
        do_reset();
        bus.mode   = 2'b00;
        bus.div    = 16'd0;
        bus.enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_oh(bp[i], (i >= 7), 1'b0);
            cycle();
        end
        reset = 1'b1;
        #2;
        push(8'h01, 3'd0, 1'b0, 1'b0);
        check_now();
        push(8'h01, 3'd0, 1'b0, 1'b0);
        cycle();
        #2;
        reset = 1'b0;
        cur_test = "bounce_to_rot_l";
        for (int p = 1; p < 8; p++) begin push_oh(p, 1'b0, 1'b0); cycle(); end
        bus.mode = 2'b01;
        #1;
        push_oh(7, 1'b0, 1'b0);
        check_now();
        push_oh(0, 1'b0, 1'b1); cycle();
        cur_test = "rot_l_to_fill";
        push_oh(1, 1'b0, 1'b0); cycle();
        bus.mode = 2'b11;
        #1;
        push(8'h03, 3'd1, 1'b0, 1'b0);
        check_now();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.mode   = 2'b00;
        bus.div    = 16'd0;
        #1;
        test_reset();
        test_bounce();
        test_prescaler();
        test_rotate();
        test_fill();
        test_mode_switch();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
